vanilla_wb_port_sched: RTL and testbench

//  Shares one register-file write-back port among num_req_p requesters (e.g. remote-load

---
 rtl/vanilla_wb_port_sched_if.sv | 23 ++
 rtl/vanilla_wb_port_sched.sv | 130 +++++++++++++
 tb/tb_vanilla_wb_port_sched.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/vanilla_wb_port_sched_if.sv
// rtl/vanilla_wb_port_sched_if.sv - request/grant bundle for the shared write-back port scheduler
interface vanilla_wb_port_sched_if #(
    parameter int num_req_p = 4,
    parameter int lg_req_p  = (num_req_p > 1) ? $clog2(num_req_p) : 1
);
    logic [num_req_p-1:0] reqs;
    logic [num_req_p-1:0] lock;
    logic                 ready;
    logic [num_req_p-1:0] grants;
    logic [lg_req_p-1:0]  grant_id;
    logic                 valid;
    logic                 starved;

    modport master (
        output reqs, lock, ready,
        input  grants, grant_id, valid, starved
    );

    modport slave (
        input  reqs, lock, ready,
        output grants, grant_id, valid, starved
    );
endinterface

// File: rtl/vanilla_wb_port_sched.sv
// rtl/vanilla_wb_port_sched.sv - N-way write-back port arbiter: round-robin, grant lock, starvation guard
module vanilla_wb_port_sched #(
    parameter int num_req_p  = 4,
    parameter int max_wait_p = 8,
    parameter int max_lock_p = 4
) (
    input logic                    clk_i,
    input logic                    reset_i,
    vanilla_wb_port_sched_if.slave wb
);
    localparam int lg_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int wc_w_lp   = $clog2(max_wait_p + 1);
    localparam int lc_w_lp   = $clog2(max_lock_p + 1);
    localparam logic [wc_w_lp-1:0] wait_max_lp = wc_w_lp'(max_wait_p);
    localparam logic [wc_w_lp-1:0] wait_one_lp = wc_w_lp'(1);
    localparam logic [lc_w_lp-1:0] lock_one_lp = lc_w_lp'(1);

    logic [lg_req_lp-1:0] last_r, last_n;
    logic [lg_req_lp-1:0] owner_r, owner_n;
    logic                 locked_r, locked_n;
    logic [lc_w_lp-1:0]   lock_cnt_r, lock_cnt_n;
    logic [wc_w_lp-1:0]   wait_cnt_r [num_req_p];
    logic [wc_w_lp-1:0]   wait_cnt_n [num_req_p];

    logic                 starve_hit, lock_hit, rr_hit;
    logic [lg_req_lp-1:0] starve_idx, rr_idx, rr_cand;
    logic                 grant_v, by_lock, by_starve;
    logic [lg_req_lp-1:0] grant_idx;
    logic [num_req_p-1:0] grants;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_r     <= '0;
            owner_r    <= '0;
            locked_r   <= 1'b0;
            lock_cnt_r <= '0;
            for (int i = 0; i < num_req_p; i++) wait_cnt_r[i] <= '0;
        end else begin
            last_r     <= last_n;
            owner_r    <= owner_n;
            locked_r   <= locked_n;
            lock_cnt_r <= lock_cnt_n;
            for (int i = 0; i < num_req_p; i++) wait_cnt_r[i] <= wait_cnt_n[i];
        end
    end

    // Grant selection: starvation beats lock beats round-robin, all gated by ready.
    always_comb begin
        starve_hit = 1'b0;
        starve_idx = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            if (wb.reqs[i] && wait_cnt_r[i] == wait_max_lp) begin
                starve_hit = 1'b1;
                starve_idx = lg_req_lp'(i);
            end
        end

        lock_hit = locked_r && wb.reqs[owner_r];

        // Scan downward so the slot right after last_r is the final (winning) assignment.
        rr_hit  = 1'b0;
        rr_idx  = '0;
        rr_cand = '0;
        for (int k = num_req_p; k >= 1; k--) begin
            rr_cand = lg_req_lp'((int'(last_r) + k) % num_req_p);
            if (wb.reqs[rr_cand]) begin
                rr_hit = 1'b1;
                rr_idx = rr_cand;
            end
        end

        grant_v   = 1'b0;
        by_lock   = 1'b0;
        by_starve = 1'b0;
        grant_idx = '0;
        if (wb.ready) begin
            if (starve_hit) begin
                grant_v   = 1'b1;
                by_starve = 1'b1;
                grant_idx = starve_idx;
            end else if (lock_hit) begin
                grant_v   = 1'b1;
                by_lock   = 1'b1;
                grant_idx = owner_r;
            end else if (rr_hit) begin
                grant_v   = 1'b1;
                grant_idx = rr_idx;
            end
        end

        grants = '0;
        if (grant_v) grants[grant_idx] = 1'b1;

        wb.grants   = grants;
        wb.grant_id = grant_idx;
        wb.valid    = |wb.reqs;
        wb.starved  = by_starve;
    end

    always_comb begin
        last_n     = last_r;
        owner_n    = owner_r;
        locked_n   = locked_r;
        lock_cnt_n = lock_cnt_r;

        if (grant_v) begin
            last_n = grant_idx;
            if (by_lock) begin
                lock_cnt_n = lock_cnt_r + lock_one_lp;
                locked_n   = wb.lock[grant_idx] && (int'(lock_cnt_r) + 1 < max_lock_p);
            end else begin
                owner_n    = grant_idx;
                lock_cnt_n = lock_one_lp;
                locked_n   = wb.lock[grant_idx] && (max_lock_p > 1);
            end
        end else if (locked_r && !wb.reqs[owner_r]) begin
            locked_n = 1'b0;
        end

        // Counters only advance on cycles where the port could have served the requester.
        for (int i = 0; i < num_req_p; i++) begin
            wait_cnt_n[i] = wait_cnt_r[i];
            if (grants[i] || !wb.reqs[i]) begin
                wait_cnt_n[i] = '0;
            end else if (wb.ready && wait_cnt_r[i] != wait_max_lp) begin
                wait_cnt_n[i] = wait_cnt_r[i] + wait_one_lp;
            end
        end
    end
endmodule

// File: tb/tb_vanilla_wb_port_sched.sv
// tb/tb_vanilla_wb_port_sched.sv - scoreboard bench for vanilla_wb_port_sched (lock cap 4 and 8 instances)
module tb_vanilla_wb_port_sched;
    localparam int max_wait_c = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] reqs;
    logic [3:0] lock;
    logic       ready;

    vanilla_wb_port_sched_if #(.num_req_p(4)) if_a ();
    vanilla_wb_port_sched_if #(.num_req_p(4)) if_b ();

    assign if_a.reqs  = reqs;
    assign if_a.lock  = lock;
    assign if_a.ready = ready;
    assign if_b.reqs  = reqs;
    assign if_b.lock  = lock;
    assign if_b.ready = ready;

    vanilla_wb_port_sched #(.num_req_p(4), .max_wait_p(3), .max_lock_p(4)) dut_a (
        .clk_i(clk), .reset_i(rst), .wb(if_a.slave)
    );
    vanilla_wb_port_sched #(.num_req_p(4), .max_wait_p(3), .max_lock_p(8)) dut_b (
        .clk_i(clk), .reset_i(rst), .wb(if_b.slave)
    );

    typedef struct {
        logic [3:0] ga;
        logic [1:0] ia;
        logic       sa;
        logic [3:0] gb;
        logic [1:0] ib;
        logic       sb;
        logic       v;
        string      name;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   waits [2][4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] l, input logic rd,
                        input logic [3:0] ga, input logic [1:0] ia, input logic sa,
                        input logic [3:0] gb, input logic [1:0] ib, input logic sb,
                        input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reqs  = r;
        lock  = l;
        ready = rd;
        e.ga = ga; e.ia = ia; e.sa = sa;
        e.gb = gb; e.ib = ib; e.sb = sb;
        e.v = |r;
        e.name = nm;
        sbq.push_back(e);
    endtask

    task automatic same(input logic [3:0] r, input logic [3:0] l, input logic rd,
                        input logic [3:0] g, input logic [1:0] id, input logic st,
                        input string nm);
        step(r, l, rd, g, id, st, g, id, st, nm);
    endtask

    // One reset edge with caller-chosen inputs, then an idle cycle with no requests.
    task automatic reset_tb(input logic [3:0] r, input logic [3:0] l);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        reqs  = r;
        lock  = l;
        ready = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        reqs  = 4'b0000;
        lock  = 4'b0000;
        ready = 1'b1;
    endtask

    // Monitor: pops expectations and runs invariant checks on both instances every cycle.
    initial begin
        exp_t e;
        logic [3:0] g;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check({e.name, " a.grants"},   32'(if_a.grants),   32'(e.ga));
                check({e.name, " a.grant_id"}, 32'(if_a.grant_id), 32'(e.ia));
                check({e.name, " a.starved"},  32'(if_a.starved),  32'(e.sa));
                check({e.name, " a.valid"},    32'(if_a.valid),    32'(e.v));
                check({e.name, " b.grants"},   32'(if_b.grants),   32'(e.gb));
                check({e.name, " b.grant_id"}, 32'(if_b.grant_id), 32'(e.ib));
                check({e.name, " b.starved"},  32'(if_b.starved),  32'(e.sb));
                check({e.name, " b.valid"},    32'(if_b.valid),    32'(e.v));
            end
            for (int d = 0; d < 2; d++) begin
                g = (d == 0) ? if_a.grants : if_b.grants;
                check($sformatf("onehot dut%0d", d), 32'($onehot0(g)), 32'd1);
                check($sformatf("subset dut%0d", d), 32'(g & ~reqs), 32'd0);
                if (!ready) check($sformatf("not_ready_idle dut%0d", d), 32'(g), 32'd0);
                for (int i = 0; i < 4; i++) begin
                    if (rst || g[i] || !reqs[i]) waits[d][i] = 0;
                    else if (ready) waits[d][i] = waits[d][i] + 1;
                    if (reqs[i] && !rst)
                        check($sformatf("wait_bound dut%0d req%0d", d, i),
                              32'(waits[d][i] <= max_wait_c), 32'd1);
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) waits[d][i] = 0;
        reqs  = 4'b0000;
        lock  = 4'b0000;
        ready = 1'b0;
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        ready = 1'b1;

        same(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "reset_idle");

        // Round-robin from index 1; req0 then req1 hit the wait limit on cycles 4 and 5.
        same(4'b1111, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0, "rr1");
        same(4'b1111, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0, "rr2");
        same(4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b0, "rr3");
        same(4'b1111, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, "rr4");
        same(4'b1111, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, "rr5");

        reset_tb(4'b0000, 4'b0000);
        same(4'b0101, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "hold1");
        same(4'b0101, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "hold2");
        same(4'b0101, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "hold3");
        same(4'b0101, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0, "hold_release");

        // Lock cap: req1 drops every other cycle so its wait never reaches the limit.
        reset_tb(4'b0000, 4'b0000);
        same(4'b0001, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, "cap1");
        same(4'b0011, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, "cap2");
        same(4'b0001, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, "cap3");
        same(4'b0011, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, "cap4");
        step(4'b0011, 4'b0001, 1'b1, 4'b0010, 2'd1, 1'b0, 4'b0001, 2'd0, 1'b0, "cap5");

        // Starvation breaks a lock.
        reset_tb(4'b0000, 4'b0000);
        same(4'b0001, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, "starve1");
        same(4'b0011, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, "starve2");
        same(4'b0011, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, "starve3");
        same(4'b0011, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, "starve4");
        same(4'b0011, 4'b0001, 1'b1, 4'b0010, 2'd1, 1'b1, "starve5");
        same(4'b0011, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, "starve6");

        // Owner drops its request while the port is busy: lock released.
        reset_tb(4'b0000, 4'b0000);
        same(4'b0100, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b0, "drop1");
        same(4'b0011, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "drop2");
        same(4'b0111, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0, "drop3");

        reset_tb(4'b0000, 4'b0000);
        for (int i = 0; i < 4; i++)
            same(4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0, $sformatf("single%0d", i));

        // Reset while locked with nonzero wait counters.
        reset_tb(4'b0000, 4'b0000);
        same(4'b0001, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, "midlock1");
        same(4'b0111, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, "midlock2");
        reset_tb(4'b1111, 4'b0001);
        same(4'b1111, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0, "post_reset1");
        same(4'b1111, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0, "post_reset2");
        same(4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b0, "post_reset3");
        same(4'b1111, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, "post_reset4");

        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sbq.size());
        end
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
